// File: rtl/dma_read_if.sv
// Source-memory read port and data-register port of the DMA read engine.
// The master side is the engine; the slave side is memory plus the write engine.
`timescale 1ns/1ps
interface dma_read_if #(
    parameter int ADDR_W = 16
);
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    logic              reg_wen;
    logic [7:0]        reg_wdata;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output mem_ren,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata,
        output reg_wen,
        output reg_wdata,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  mem_ren,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata,
        input  reg_wen,
        input  reg_wdata,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/dma_read_engine.sv
// Source-side half of the memory copier: reads one word per address, writes it into
// the data register and holds it until the write engine consumes it.
`timescale 1ns/1ps
module dma_read_engine #(
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    dma_read_if.master        bus
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HANDOFF,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic              err_q, err_nxt;
    logic              zdone_q, zdone_nxt;
    logic              wvalid_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            tcnt      <= '0;
            err_q     <= 1'b0;
            zdone_q   <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            remaining <= remaining_nxt;
            tcnt      <= tcnt_nxt;
            err_q     <= err_nxt;
            zdone_q   <= zdone_nxt;
            wvalid_q  <= (state_nxt == HANDOFF);
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        tcnt_nxt      = tcnt;
        err_nxt       = 1'b0;
        zdone_nxt     = 1'b0;
        bus.mem_ren   = 1'b0;
        bus.mem_addr  = '0;
        bus.reg_wen   = 1'b0;
        bus.reg_wdata = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        cur_addr_nxt  = src_addr;
                        remaining_nxt = length;
                        state_nxt     = REQ;
                    end else begin
                        zdone_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                bus.mem_ren  = 1'b1;
                bus.mem_addr = cur_addr;
                tcnt_nxt     = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // Pass-through so the data register captures on the same edge as rvalid.
                if (bus.mem_rvalid) begin
                    bus.reg_wen   = 1'b1;
                    bus.reg_wdata = bus.mem_rdata;
                    state_nxt     = HANDOFF;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                    if (tcnt_nxt == TCNT_W'(TIMEOUT)) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            HANDOFF: begin
                if (bus.word_ready) begin
                    cur_addr_nxt  = cur_addr + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    state_nxt     = (remaining == LEN_W'(1)) ? DONE : REQ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything, including a start sampled in the same cycle.
        if (abort) begin
            state_nxt     = IDLE;
            cur_addr_nxt  = cur_addr;
            remaining_nxt = remaining;
            err_nxt       = 1'b0;
            zdone_nxt     = 1'b0;
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE) || zdone_q;
    assign err            = err_q;
    assign bus.word_valid = wvalid_q;

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine with a one-cycle-latency source memory model.
`timescale 1ns/1ps
module tb_dma_read_engine;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic        abort;
    logic [15:0] src_addr;
    logic [7:0]  length;
    logic        busy, done, err;
    logic        word_ready;
    logic        resp_en;
    logic        spur_rvalid;
    logic [7:0]  spur_rdata;
    logic        rsp_vld;
    logic [7:0]  rsp_data;

    dma_read_if #(.ADDR_W(16)) bus ();

    dma_read_engine #(.ADDR_W(16), .LEN_W(8), .TIMEOUT(15)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus.master)
    );

    assign bus.mem_rvalid = rsp_vld | spur_rvalid;
    assign bus.mem_rdata  = rsp_vld ? rsp_data : spur_rdata;
    assign bus.word_ready = word_ready;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents keyed by the low three address bits.
    logic [7:0] tab [0:7];
    initial begin
        tab[0] = 8'hA1; tab[1] = 8'hB2; tab[2] = 8'hC3; tab[3] = 8'hD4;
        tab[4] = 8'hE5; tab[5] = 8'hF6; tab[6] = 8'h07; tab[7] = 8'h18;
    end

    logic        ren_seen;
    logic [15:0] addr_seen;
    logic [15:0] ren_q [$];
    logic [7:0]  wen_q [$];
    int n_done, n_err, n_busy, cyc, done_cyc, err_cyc;

    initial begin
        ren_seen = 1'b0; addr_seen = '0;
        n_done = 0; n_err = 0; n_busy = 0; cyc = 0; done_cyc = 0; err_cyc = 0;
    end

    always @(negedge CLK) begin
        cyc++;
        if (bus.mem_ren) ren_q.push_back(bus.mem_addr);
        if (bus.reg_wen) wen_q.push_back(bus.reg_wdata);
        if (done) begin n_done++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (busy) n_busy++;
        ren_seen  = bus.mem_ren;
        addr_seen = bus.mem_addr;
    end

    always @(posedge CLK) begin
        #2;
        if (ren_seen && resp_en) begin
            rsp_vld  = 1'b1;
            rsp_data = tab[addr_seen[2:0]];
        end else begin
            rsp_vld  = 1'b0;
            rsp_data = 8'h00;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int b_ren, b_wen, b_done, b_err, b_busy, b_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mark();
        b_ren = ren_q.size(); b_wen = wen_q.size();
        b_done = n_done; b_err = n_err; b_busy = n_busy; b_cyc = cyc;
    endtask

    task automatic start_xfer(input logic [15:0] a, input logic [7:0] len);
        src_addr = a; length = len; start = 1'b1;
        tick();
        start = 1'b0;
        mark();
    endtask

    task automatic wait_end(input string tag, input int budget);
        int i = 0;
        while (((n_done - b_done) + (n_err - b_err)) == 0 && i < budget) begin
            tick();
            i++;
        end
        check({tag, "_ended"}, 32'(((n_done - b_done) + (n_err - b_err)) != 0), 32'd1);
        tick();
        tick();
    endtask

    function automatic logic [31:0] ren_at(input int i);
        if (b_ren + i < ren_q.size()) return 32'(ren_q[b_ren + i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wen_at(input int i);
        if (b_wen + i < wen_q.size()) return 32'(wen_q[b_wen + i]);
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        nRST = 1'b0; start = 1'b0; abort = 1'b0; src_addr = '0; length = '0;
        word_ready = 1'b0; resp_en = 1'b1; spur_rvalid = 1'b0; spur_rdata = '0;
        rsp_vld = 1'b0; rsp_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ctrl", {26'd0, busy, done, err, bus.mem_ren, bus.reg_wen, bus.word_valid}, 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.reg_wdata), 32'd0);
        nRST = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Basic three-word copy
        word_ready = 1'b1;
        start_xfer(16'h0010, 8'd3);
        check("basic_busy_at_req", 32'(busy), 32'd1);
        wait_end("basic", 40);
        check("basic_nren", 32'(ren_q.size() - b_ren), 32'd3);
        check("basic_addr0", ren_at(0), 32'h0010);
        check("basic_addr1", ren_at(1), 32'h0011);
        check("basic_addr2", ren_at(2), 32'h0012);
        check("basic_nwen", 32'(wen_q.size() - b_wen), 32'd3);
        check("basic_data0", wen_at(0), 32'hA1);
        check("basic_data1", wen_at(1), 32'hB2);
        check("basic_data2", wen_at(2), 32'hC3);
        check("basic_ndone", 32'(n_done - b_done), 32'd1);
        check("basic_done_cyc", 32'(done_cyc - b_cyc), 32'd10);
        check("basic_busy_cycles", 32'(n_busy - b_busy), 32'd10);
        check("basic_nerr", 32'(n_err - b_err), 32'd0);

        // Backpressure in the first handoff
        word_ready = 1'b0;
        start_xfer(16'h0020, 8'd2);
        tick();
        check("bp_wvalid_in_wait", 32'(bus.word_valid), 32'd0);
        tick();
        repeat (5) tick();
        check("bp_wvalid_held", 32'(bus.word_valid), 32'd1);
        check("bp_one_ren", 32'(ren_q.size() - b_ren), 32'd1);
        check("bp_one_wen", 32'(wen_q.size() - b_wen), 32'd1);
        word_ready = 1'b1;
        wait_end("bp", 40);
        check("bp_addr1", ren_at(1), 32'h0021);
        check("bp_data0", wen_at(0), 32'hA1);
        check("bp_data1", wen_at(1), 32'hB2);
        check("bp_ndone", 32'(n_done - b_done), 32'd1);

        // Address wrap
        start_xfer(16'hFFFF, 8'd2);
        wait_end("wrap", 40);
        check("wrap_addr0", ren_at(0), 32'hFFFF);
        check("wrap_addr1", ren_at(1), 32'h0000);
        check("wrap_data1", wen_at(1), 32'hA1);

        // Zero length
        start_xfer(16'h0040, 8'd0);
        check("zlen_done", 32'(done), 32'd1);
        check("zlen_busy", 32'(busy), 32'd0);
        tick();
        check("zlen_done_clear", 32'(done), 32'd0);
        tick();
        check("zlen_nren", 32'(ren_q.size() - b_ren), 32'd0);
        check("zlen_busy_cycles", 32'(n_busy - b_busy), 32'd0);
        check("zlen_ndone", 32'(n_done - b_done), 32'd1);

        // Read timeout, then a normal transfer
        resp_en = 1'b0;
        start_xfer(16'h0050, 8'd1);
        wait_end("tmo", 60);
        check("tmo_nerr", 32'(n_err - b_err), 32'd1);
        check("tmo_err_cyc", 32'(err_cyc - b_cyc), 32'd17);
        check("tmo_busy_cycles", 32'(n_busy - b_busy), 32'd16);
        check("tmo_ndone", 32'(n_done - b_done), 32'd0);
        check("tmo_nwen", 32'(wen_q.size() - b_wen), 32'd0);
        resp_en = 1'b1;
        start_xfer(16'h0063, 8'd1);
        wait_end("after_tmo", 40);
        check("after_tmo_ndone", 32'(n_done - b_done), 32'd1);
        check("after_tmo_data", wen_at(0), 32'hD4);

        // Abort in the second handoff of four
        start_xfer(16'h0070, 8'd4);
        repeat (5) tick();
        check("abort_in_handoff", 32'(bus.word_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {29'd0, busy, done, bus.word_valid}, 32'd0);
        repeat (4) tick();
        check("abort_ndone", 32'(n_done - b_done), 32'd0);
        check("abort_nerr", 32'(n_err - b_err), 32'd0);
        check("abort_nren", 32'(ren_q.size() - b_ren), 32'd2);

        // Asynchronous reset while waiting, followed by a late response
        resp_en = 1'b0;
        start_xfer(16'h0080, 8'd2);
        tick();
        check("rstw_busy", 32'(busy), 32'd1);
        nRST = 1'b0;
        #1;
        check("rstw_outputs", {29'd0, busy, bus.mem_ren, bus.word_valid}, 32'd0);
        spur_rvalid = 1'b1; spur_rdata = 8'h5A;
        tick();
        nRST = 1'b1;
        tick();
        check("rstw_late_wen", 32'(bus.reg_wen), 32'd0);
        check("rstw_late_wdata", 32'(bus.reg_wdata), 32'd0);
        spur_rvalid = 1'b0;
        tick();
        check("rstw_nwen", 32'(wen_q.size() - b_wen), 32'd0);
        check("rstw_idle", 32'(busy), 32'd0);
        resp_en = 1'b1;

        // Spurious rvalid in IDLE and HANDOFF, start while busy
        spur_rvalid = 1'b1; spur_rdata = 8'hEE;
        #1;
        check("spur_idle_wen", 32'(bus.reg_wen), 32'd0);
        tick();
        spur_rvalid = 1'b0;
        word_ready = 1'b0;
        start_xfer(16'h0094, 8'd2);
        tick();
        tick();
        spur_rvalid = 1'b1;
        start = 1'b1; src_addr = 16'h1234; length = 8'd7;
        #1;
        check("spur_handoff_wen", 32'(bus.reg_wen), 32'd0);
        tick();
        spur_rvalid = 1'b0; start = 1'b0;
        word_ready = 1'b1;
        wait_end("spur", 40);
        check("spur_nren", 32'(ren_q.size() - b_ren), 32'd2);
        check("spur_addr0", ren_at(0), 32'h0094);
        check("spur_addr1", ren_at(1), 32'h0095);
        check("spur_nwen", 32'(wen_q.size() - b_wen), 32'd2);
        check("spur_data0", wen_at(0), 32'hE5);
        check("spur_data1", wen_at(1), 32'hF6);
        check("spur_ndone", 32'(n_done - b_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
